// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants and the baud divisor helper used by
//            baud_tick_gen and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_DIV_W       = 16;
    localparam int unsigned c_DEFAULT_DIV = 651;  // 100 MHz / (9600 * 16)
    localparam int unsigned c_OVERSAMPLE  = 16;

    // Round-to-nearest divisor for a given clock, baud rate and oversample.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        longint unsigned w_num;
        longint unsigned w_den;
        w_num = 64'(clk_hz);
        w_den = 64'(baud) * 64'(os);
        if (w_den == 64'd0) begin
            return 0;
        end
        return 32'((w_num + (w_den >> 1)) / w_den);
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_div_ctr.sv
`default_nettype none
// ============================================================================
// Module   : baud_div_ctr
// Purpose  : Loadable modulo-N counter with enable and synchronous clear.
//            Emits a registered one-cycle tick every i_div enabled cycles and
//            exposes the combinational wrap event so the parent can update
//            state in the same edge as the tick.
// Revision : 1.0 - initial release
// ============================================================================
module baud_div_ctr import uart_pkg::*; #(
    parameter int unsigned DIV_W = c_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_wrap,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;
    logic             r_tick;
    logic             w_last;

    // ">=" rather than "==": a divisor applied while the counter is frozen
    // may be smaller than the held count; the counter then wraps at once
    // instead of running all the way round the register.
    assign w_last = (r_count >= (i_div - c_ONE));
    // Clear has priority over ticking.
    assign o_wrap = i_en & ~i_clr & w_last;
    assign o_tick = r_tick;

    // Count enabled cycles, wrap at i_div-1 and register the tick.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= o_wrap;
            if (o_wrap) begin
                r_count <= '0;
            end else if (i_en) begin
                r_count <= r_count + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Runtime-programmable UART baud generator. Produces an oversample
//            tick, a mid-bit sample tick, a bit tick and a 50% duty bit
//            clock; supports shadowed divisor writes and phase resync.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen import uart_pkg::*; #(
    parameter int unsigned DIV_W       = c_DIV_W,
    parameter int unsigned DEFAULT_DIV = c_DEFAULT_DIV,
    parameter int unsigned OVERSAMPLE  = c_OVERSAMPLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    input  logic             resync,
    output logic             div_busy,
    output logic             div_err,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             tx_tick,
    output logic             bclk
);

    localparam int unsigned          c_SUB_W = $clog2(OVERSAMPLE);
    localparam logic [c_SUB_W-1:0]   c_MID   = c_SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SUB_W-1:0]   c_LAST  = c_SUB_W'(OVERSAMPLE - 1);
    localparam logic [c_SUB_W-1:0]   c_HALF  = c_SUB_W'(OVERSAMPLE / 2);
    localparam logic [c_SUB_W-1:0]   c_SONE  = c_SUB_W'(1);
    localparam logic [DIV_W-1:0]     c_DEF   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]     c_MIN   = DIV_W'(2);

    logic [DIV_W-1:0]   r_div_cur;
    logic [DIV_W-1:0]   r_div_pend;
    logic               r_busy;
    logic               r_err;
    logic [c_SUB_W-1:0] r_sub;
    logic               r_mid;
    logic               r_tx;
    logic               r_bclk;

    logic               w_wrap;
    logic               w_os_tick;
    logic               w_bad;
    logic               w_apply;
    logic [c_SUB_W-1:0] w_sub_next;

    baud_div_ctr #(
        .DIV_W (DIV_W)
    ) u_div_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .i_clr  (resync),
        .i_div  (r_div_cur),
        .o_wrap (w_wrap),
        .o_tick (w_os_tick)
    );

    // A divisor below 2 cannot produce a tick pattern and is rejected.
    assign w_bad      = div_wr & (div_in < c_MIN);
    // Pending divisor lands at an os period boundary, on resync, or
    // straight away while the generator is frozen.
    assign w_apply    = r_busy & (w_wrap | resync | ~en);
    assign w_sub_next = w_wrap ? (r_sub + c_SONE) : r_sub;

    // Divisor shadow: accept writes, flag rejects, apply at a safe boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cur  <= c_DEF;
            r_div_pend <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_apply) begin
                r_div_cur <= r_div_pend;
            end
            // A write coinciding with an apply keeps busy set for the new value.
            if (div_wr && !w_bad) begin
                r_div_pend <= div_in;
                r_busy     <= 1'b1;
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Bit-phase counter, mid/bit ticks and the bit clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub  <= '0;
            r_mid  <= 1'b0;
            r_tx   <= 1'b0;
            r_bclk <= 1'b0;
        end else if (resync) begin
            r_sub  <= '0;
            r_mid  <= 1'b0;
            r_tx   <= 1'b0;
            r_bclk <= 1'b1;
        end else begin
            r_mid <= w_wrap & (r_sub == c_MID);
            r_tx  <= w_wrap & (r_sub == c_LAST);
            if (en) begin
                r_sub  <= w_sub_next;
                r_bclk <= (w_sub_next < c_HALF);
            end
        end
    end

    assign div_busy = r_busy;
    assign div_err  = r_err;
    assign os_tick  = w_os_tick;
    assign mid_tick = r_mid;
    assign tx_tick  = r_tx;
    assign bclk     = r_bclk;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_gen
// Purpose  : Self-checking bench for baud_tick_gen (DEFAULT_DIV = 4,
//            OVERSAMPLE = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;
    import uart_pkg::*;

    localparam logic [5:0] B_OS    = 6'b100000;
    localparam logic [5:0] B_MID   = 6'b010000;
    localparam logic [5:0] B_TX    = 6'b001000;
    localparam logic [5:0] B_BCLK  = 6'b000100;
    localparam logic [5:0] B_BUSY  = 6'b000010;
    localparam logic [5:0] B_ERR   = 6'b000001;
    localparam logic [5:0] M_ALL   = 6'b111111;
    localparam logic [5:0] M_NO_OS = 6'b011111;

    logic        clk;
    logic        rst;
    logic        en;
    logic        div_wr;
    logic [15:0] div_in;
    logic        resync;
    logic        div_busy;
    logic        div_err;
    logic        os_tick;
    logic        mid_tick;
    logic        tx_tick;
    logic        bclk;
    logic [5:0]  w_act;

    assign w_act = {os_tick, mid_tick, tx_tick, bclk, div_busy, div_err};

    baud_tick_gen #(
        .DIV_W       (16),
        .DEFAULT_DIV (4),
        .OVERSAMPLE  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .resync   (resync),
        .div_busy (div_busy),
        .div_err  (div_err),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .tx_tick  (tx_tick),
        .bclk     (bclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic        en;
        logic        wr;
        logic [15:0] din;
        logic        rs;
        logic        rst;
        logic [5:0]  exp;
        logic [5:0]  mask;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] exp;
        logic [5:0] mask;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input string name, input int n, input logic e,
                                input logic w, input logic [15:0] d,
                                input logic rs, input logic r,
                                input logic [5:0] exp, input logic [5:0] mask);
        vec_t v;
        v.name = name; v.n = n; v.en = e; v.wr = w; v.din = d;
        v.rs = rs; v.rst = r; v.exp = exp; v.mask = mask;
        vecs.push_back(v);
    endfunction

    task automatic compare_out();
        sb_t s;
        s = sbq.pop_front();
        checks++;
        if (((w_act ^ s.exp) & s.mask) != 6'b0) begin
            failures++;
            $display("FAIL %s @%0t: got os/mid/tx/bclk/busy/err=%b required %b (mask %b)",
                     s.name, $time, w_act, s.exp, s.mask);
        end
    endtask

    task automatic cycle(input logic e, input logic w, input logic [15:0] d,
                         input logic rs, input logic r, input string name,
                         input logic [5:0] exp, input logic [5:0] mask);
        sb_t s;
        en = e; div_wr = w; div_in = d; resync = rs; rst = r;
        s.name = name; s.exp = exp; s.mask = mask;
        sbq.push_back(s);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        logic [5:0] e;
        int unsigned dv;

        // Divisor error: write of 1 rejected, period unchanged.
        add("err_rst", 2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("err_run", 1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("err_wr1", 1, 1, 1, 16'd1, 0, 0, B_BCLK | B_ERR, M_ALL);
        add("err_clr", 1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("err_os4", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("err_gap", 3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("err_os8", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        // Divisor change to 10 written at cycle 5.
        add("wr_rst",  2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("wr_run",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("wr_os4",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("wr_10",   1, 1, 1, 16'd10, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("wr_busy", 2, 1, 0, 16'd0, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("wr_os8",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("wr_gap1", 9, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("wr_os18", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("wr_gap2", 9, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("wr_os28", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        // Enable dropped for 20 cycles from cycle 6.
        add("en_rst",  2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("en_run",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("en_os4",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("en_c5",   1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("en_off",  20, 0, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("en_on",   2, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("en_os28", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        // Resync in the cycle a tick is due.
        add("rs_rst",  2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("rs_run",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("rs_os4",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("rs_run2", 3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("rs_hit",  1, 1, 0, 16'd0, 1, 0, B_BCLK, M_ALL);
        add("rs_gap",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("rs_os1",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("rs_mid0", 27, 1, 0, 16'd0, 0, 0, B_BCLK, M_NO_OS);
        add("rs_mid",  1, 1, 0, 16'd0, 0, 0, B_OS | B_MID, M_ALL);
        // Reset mid-bit with a divisor pending.
        add("mr_rst",  2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("mr_run",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("mr_os4",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("mr_wr",   1, 1, 1, 16'd10, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("mr_hit",  1, 1, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("mr_run2", 3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("mr_os4b", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("mr_run3", 3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("mr_os8",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        // Last write wins, write colliding with apply, en=0 apply, resync with en=0.
        add("lw_rst",  2, 0, 0, 16'd0, 0, 1, 6'b0, M_ALL);
        add("lw_run",  3, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_os4",  1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_wr6",  1, 1, 1, 16'd6, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("lw_busy", 1, 1, 0, 16'd0, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("lw_wr3",  1, 1, 1, 16'd3, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("lw_coll", 1, 1, 1, 16'd5, 0, 0, B_OS | B_BUSY | B_BCLK, M_ALL);
        add("lw_busy2",2, 1, 0, 16'd0, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("lw_os11", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_gap5", 4, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_os16", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_offwr",1, 0, 1, 16'd2, 0, 0, B_BUSY | B_BCLK, M_ALL);
        add("lw_offap",1, 0, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_d2a",  1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_os20", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_d2b",  1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_os22", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_rsoff",1, 0, 0, 16'd0, 1, 0, B_BCLK, M_ALL);
        add("lw_rs1",  1, 1, 0, 16'd0, 0, 0, B_BCLK, M_ALL);
        add("lw_rsos", 1, 1, 0, 16'd0, 0, 0, B_OS | B_BCLK, M_ALL);
        add("lw_rsgap",13, 1, 0, 16'd0, 0, 0, B_BCLK, M_NO_OS);
        add("lw_rsmid",1, 1, 0, 16'd0, 0, 0, B_OS | B_MID, M_ALL);

        // Package helper: 100 MHz, 9600 baud, x16.
        dv = calc_div(100_000_000, 9600, 16);
        checks++;
        if (dv != 651) begin
            failures++;
            $display("FAIL calc_div: got %0d required 651", dv);
        end

        // Default rate: closed-form tick pattern over two bit periods.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, "reset_state", 6'b0, M_ALL);
        end
        for (int k = 1; k <= 130; k++) begin
            e = 6'b0;
            if (k % 4 == 0)   e = e | B_OS;
            if (k % 64 == 32) e = e | B_MID;
            if (k % 64 == 0)  e = e | B_TX;
            if (k % 64 < 32)  e = e | B_BCLK;
            cycle(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, "default_rate", e, M_ALL);
        end

        // Table-driven corner cases.
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                cycle(vecs[i].en, vecs[i].wr, vecs[i].din, vecs[i].rs,
                      vecs[i].rst, vecs[i].name, vecs[i].exp, vecs[i].mask);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
